// File: rtl/epsm_wr_sched.sv
// Purpose: queue decoded CPU writes to the EPSM window and replay them to the YM2608 with safe bus timing.
// Latency: a write accepted in cycle 0 drives cs_n low in cycle 2, and wr_n low SETUP_CYC cycles later.
// Backpressure: none upstream; a write that finds the queue full with no pop in that cycle is dropped and latched in overflow.
//
// Ports:
//   clk, rst              50 MHz clock, synchronous active-high reset
//   wr_stb, wr_a, wr_d    one-cycle CPU write capture (address bits [1:0], data)
//   ovf_clr               clears the sticky overflow flag (a same-cycle drop wins)
//   ym_a, ym_d            chip address/data, updated only when an entry is popped
//   ym_cs_n, ym_wr_n      chip select and write strobe, active low
//   busy, fifo_full, fifo_empty, overflow, level   status
module epsm_wr_sched #(
    parameter int DEPTH     = 16,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 6,
    parameter int ADDR_WAIT = 107,
    parameter int DATA_WAIT = 519
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic [1:0] wr_a,
    input  logic [7:0] wr_d,
    input  logic       ovf_clr,
    output logic [1:0] ym_a,
    output logic [7:0] ym_d,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic [6:0] level
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAXP = max2(max2(SETUP_CYC, PULSE_CYC), max2(ADDR_WAIT, DATA_WAIT));
    localparam int CW   = (MAXP > 0) ? $clog2(MAXP + 1) : 1;

    // Counters run from N-1 down to 0, so a phase lasts exactly N cycles.
    localparam logic [CW-1:0] SETUP_LD = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CW-1:0] PULSE_LD = CW'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CW-1:0] AWAIT_LD = CW'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
    localparam logic [CW-1:0] DWAIT_LD = CW'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      count_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [9:0]      mem_q [DEPTH];
    logic [1:0]      ym_a_q;
    logic [7:0]      ym_d_q;
    logic            ovf_q;

    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            wait_nz;

    assign pop     = (state_q == S_IDLE) && (count_q != 7'd0);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push_ok = wr_stb && ((count_q < 7'(DEPTH)) || pop);
    assign drop    = wr_stb && !push_ok;
    // Address-port writes (A0=0) need the short recovery, data-port writes the long one.
    assign wait_nz = ym_a_q[0] ? (DATA_WAIT > 0) : (ADDR_WAIT > 0);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (SETUP_CYC > 0)      state_d = S_SETUP;
                    else if (PULSE_CYC > 0) state_d = S_STROBE;
                    else                    state_d = S_HOLD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) state_d = (PULSE_CYC > 0) ? S_STROBE : S_HOLD;
            end
            S_STROBE: begin
                if (cnt_q == '0) state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = wait_nz ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter: reload on every state change, otherwise count down to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                S_SETUP:  cnt_d = SETUP_LD;
                S_STROBE: cnt_d = PULSE_LD;
                S_WAIT:   cnt_d = ym_a_q[0] ? DWAIT_LD : AWAIT_LD;
                default:  cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        ym_cs_n = 1'b1;
        ym_wr_n = 1'b1;
        unique case (state_q)
            S_SETUP:  ym_cs_n = 1'b0;
            S_STROBE: begin
                ym_cs_n = 1'b0;
                ym_wr_n = 1'b0;
            end
            S_HOLD:   ym_cs_n = 1'b0;
            default:  ;
        endcase
    end

    // ---------------- queue and bus registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            count_q  <= 7'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ym_a_q   <= 2'd0;
            ym_d_q   <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                ym_a_q   <= mem_q[rd_ptr_q][9:8];
                ym_d_q   <= mem_q[rd_ptr_q][7:0];
            end
            if (push_ok && !pop)      count_q <= count_q + 7'd1;
            else if (pop && !push_ok) count_q <= count_q - 7'd1;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {wr_a, wr_d};
    end

    assign ym_a       = ym_a_q;
    assign ym_d       = ym_d_q;
    assign busy       = (state_q != S_IDLE) || (count_q != 7'd0);
    assign fifo_full  = (count_q == 7'(DEPTH));
    assign fifo_empty = (count_q == 7'd0);
    assign overflow   = ovf_q;
    assign level      = count_q;

endmodule

// File: tb/tb_epsm_wr_sched.sv
// Bench for the EPSM write scheduler: a queue-and-timeline reference model predicts
// accepted/dropped writes and the bus schedule; a monitor compares every cycle and
// scoreboards each transaction's address/data when chip select falls.
module tb_epsm_wr_sched;

    localparam int DEPTH = 16;
    localparam int S     = 2;
    localparam int P     = 6;
    localparam int AWT   = 107;
    localparam int DWT   = 519;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_stb;
    logic [1:0] wr_a;
    logic [7:0] wr_d;
    logic       ovf_clr;
    logic [1:0] ym_a;
    logic [7:0] ym_d;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic [6:0] level;

    always #10 clk = ~clk;

    epsm_wr_sched #(
        .DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P), .ADDR_WAIT(AWT), .DATA_WAIT(DWT)
    ) dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_a(wr_a), .wr_d(wr_d), .ovf_clr(ovf_clr),
        .ym_a(ym_a), .ym_d(ym_d), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n), .busy(busy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow), .level(level)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    // ---------------- reference model ----------------
    // Cycle t: the model consumes the inputs of cycle t at the rising edge ending it.
    // A transaction popped in cycle t occupies the bus from t+1 for S+P+1 cycles, then
    // recovers for the port-specific wait; the scheduler is free again at idle_at.
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    int         t = 0;
    int         idle_at = 0;
    int         cur_start = -1;
    logic       m_ovf = 1'b0;
    logic [9:0] m_last = 10'd0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit         pop;
        bit         acc;
        logic [9:0] e;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            idle_at   = t + 1;
            cur_start = -1;
            m_ovf     = 1'b0;
            m_last    = 10'd0;
        end else begin
            pop = (t >= idle_at) && (mq.size() > 0);
            acc = wr_stb && ((mq.size() < DEPTH) || pop);
            if (pop) begin
                e = mq.pop_front();
                exp_q.push_back(e);
                m_last    = e;
                cur_start = t + 1;
                idle_at   = t + 1 + S + P + 1 + (e[8] ? DWT : AWT);
            end
            if (acc) mq.push_back({wr_a, wr_d});
            if (wr_stb && !acc) m_ovf = 1'b1;
            else if (ovf_clr)   m_ovf = 1'b0;
        end
        t++;
    end

    // ---------------- monitor / scoreboard ----------------
    bit prev_cs = 1'b1;

    always @(negedge clk) begin : monitor
        bit         cs_low;
        bit         wr_low;
        logic [9:0] e;
        if (chk_en) begin
            cs_low = (cur_start >= 0) && (t >= cur_start) && (t < cur_start + S + P + 1);
            wr_low = (cur_start >= 0) && (t >= cur_start + S) && (t < cur_start + S + P);
            chk("cs_n",     int'(ym_cs_n),    int'(!cs_low));
            chk("wr_n",     int'(ym_wr_n),    int'(!wr_low));
            chk("ym_a",     int'(ym_a),       int'(m_last[9:8]));
            chk("ym_d",     int'(ym_d),       int'(m_last[7:0]));
            chk("level",    int'(level),      mq.size());
            chk("empty",    int'(fifo_empty), int'(mq.size() == 0));
            chk("full",     int'(fifo_full),  int'(mq.size() == DEPTH));
            chk("overflow", int'(overflow),   int'(m_ovf));
            chk("busy",     int'(busy),       int'((t < idle_at) || (mq.size() > 0)));
            if (prev_cs && !ym_cs_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: transaction a=%0h d=%0h, expected none", ym_a, ym_d);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_a", int'(ym_a), int'(e[9:8]));
                    chk("sb_d", int'(ym_d), int'(e[7:0]));
                end
            end
        end
        prev_cs = ym_cs_n;
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        wr_stb = 1'b1;
        wr_a   = a;
        wr_d   = d;
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    // Waits for busy to drop, then checks how many cycles after c0 that was.
    task automatic wait_idle(input string nm, input int c0, input int req);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, t - c0, req);
    endtask

    initial begin
        int c0;
        int n;
        rst     = 1'b1;
        wr_stb  = 1'b0;
        ovf_clr = 1'b0;
        wr_a    = 2'd0;
        wr_d    = 8'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single address-port write.
        c0 = t;
        do_write(2'd0, 8'h27);
        wait_idle("single_busy_cycles", c0, 118);
        repeat (3) @(negedge clk);

        // Address then data, one cycle apart.
        c0 = t;
        do_write(2'd0, 8'h24);
        do_write(2'd1, 8'h55);
        wait_idle("addr_data_busy_cycles", c0, 647);
        repeat (3) @(negedge clk);

        // 17 consecutive writes: the first leaves immediately, so all are accepted.
        for (int i = 0; i < 17; i++) do_write(2'($urandom), 8'($urandom));
        chk("burst17_level", int'(level), 16);
        chk("burst17_ovf", int'(overflow), 0);

        // Full queue plus a write in the very cycle the head is popped.
        n = 0;
        while (t != idle_at && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pop_cycle", int'(t == idle_at), 1);
        do_write(2'd2, 8'hA5);
        chk("full_pop_level", int'(level), 16);
        chk("full_pop_ovf", int'(overflow), 0);

        // Drop together with ovf_clr: the drop wins; ovf_clr alone then clears.
        wr_stb  = 1'b1;
        wr_a    = 2'd3;
        wr_d    = 8'h5A;
        ovf_clr = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("drop_vs_clr_ovf", int'(overflow), 1);
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_alone_ovf", int'(overflow), 0);

        // Reset during the strobe with five entries still queued.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) do_write(2'(i), 8'(8'h10 + i));
        n = 0;
        while (ym_wr_n && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_seen", int'(ym_wr_n), 0);
        chk("queued_before_rst", int'(level), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wr_n", int'(ym_wr_n), 1);
        chk("rst_cs_n", int'(ym_cs_n), 1);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_busy", int'(busy), 0);
        repeat (50) @(negedge clk);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 15000; i++) begin
            wr_stb  = ($urandom_range(0, 7) == 0);
            wr_a    = 2'($urandom);
            wr_d    = 8'($urandom);
            ovf_clr = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 4999) == 0);
            @(negedge clk);
        end
        wr_stb  = 1'b0;
        ovf_clr = 1'b0;
        rst     = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/epsm_wr_sched.md
Name: epsm_wr_sched

Overview:
Write scheduler between the cartridge's decoded CPU writes to the EPSM window ($401C-$401F) and the external YM2608 bus on the expansion header.
- Buffers CPU register writes in a small FIFO.
- Replays them to the chip with chip-safe strobe timing and post-write busy waits, so back-to-back 6502 writes never violate OPNA access timing.
- Sits beside the EPSM timer/IRQ model. Runs in the 50 MHz clk domain.

Parameters:
DEPTH, 16, FIFO entries (power of two, 2..64)
SETUP_CYC, 2, clk cycles address/data/cs valid before write strobe
PULSE_CYC, 6, clk cycles write strobe held low
ADDR_WAIT, 107, clk cycles idle after an address-port write (17 YM clocks at 8 MHz)
DATA_WAIT, 519, clk cycles idle after a data-port write (83 YM clocks)

Ports:
clk  in  1  system clock, 50 MHz, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_stb  in  1  one-cycle pulse: CPU write to $401C-$401F captured (already synchronised to clk)
wr_a  in  2  CPU address bits [1:0] of that write
wr_d  in  8  CPU write data
ovf_clr  in  1  clears sticky overflow flag
ym_a  out  2  chip A1:A0
ym_d  out  8  chip data bus (write only)
ym_cs_n  out  1  chip select, active low
ym_wr_n  out  1  write strobe, active low
busy  out  1  high whenever state != IDLE or FIFO not empty
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
overflow  out  1  sticky: a write was dropped
level  out  7  current FIFO count, 0..DEPTH

Behaviour:
Reset values:
- ym_cs_n=1, ym_wr_n=1, ym_a=0, ym_d=0.
- busy=0, fifo_empty=1, fifo_full=0, overflow=0, level=0.
- FIFO pointers cleared, state=IDLE.
- Reset mid-transaction aborts it: strobes are high the cycle after rst is sampled, and queued entries are discarded.

FIFO:
- 10-bit entries {a,d}. Push on wr_stb.
- Push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
- Otherwise the write is dropped, overflow<=1, and count is unchanged.
- Pointers wrap modulo DEPTH.
- ovf_clr clears overflow. If a drop occurs in the same cycle as ovf_clr, set wins.
- level/full/empty reflect the registered count, updated the cycle after a push/pop.

State machine (one transaction per entry):
- IDLE: if !fifo_empty, pop the head into the ym_a/ym_d registers and go to SETUP.
- SETUP: ym_cs_n=0, ym_wr_n=1, for SETUP_CYC cycles; then go to STROBE.
- STROBE: ym_cs_n=0, ym_wr_n=0, for PULSE_CYC cycles; then go to HOLD.
- HOLD: 1 cycle, ym_wr_n=1, ym_cs_n=0, a/d held; then go to WAIT.
- WAIT: ym_cs_n=1, ym_wr_n=1. Counter loads ADDR_WAIT if latched a[0]==0, else DATA_WAIT. When it reaches 0, go to IDLE.

Timing and data rules:
- ym_a/ym_d change only in the IDLE->SETUP transition and are stable from SETUP through HOLD.
- Latency: wr_stb at cycle 0 into an empty, idle block gives ym_cs_n low at cycle 2 and ym_wr_n low at cycles 2+SETUP_CYC .. 1+SETUP_CYC+PULSE_CYC.
- Back-to-back transactions: the next SETUP starts 1 cycle after returning to IDLE.
- Counters are sized to ceil(log2(max param+1)) bits. A zero parameter means that phase takes 0 cycles (state skipped), except that HOLD is always 1 cycle.
- Push while the FIFO is empty and IDLE is simultaneously popped only on the following cycle. There is no bypass.

Test Plan:
- Single address write a=0,d=0x27 with defaults -> cs_n low cycles 2..10; wr_n low cycles 4..9; ym_a=0, ym_d=0x27 held cycles 2..10; busy low at cycle 11+107=118; level back to 0 by cycle 3.
- Address then data (a=0,d=0x24; a=1,d=0x55) issued 1 cycle apart -> second cs_n falls at cycle 119, with ym_a=1, ym_d=0x55; busy clears at cycle 119+9+519=647.
- 17 writes with consecutive wr_stb, DEPTH=16 -> level peaks at 15 or 16; overflow=1 only if a push hit full with no concurrent pop; every accepted entry appears on ym_d in push order.
- Full FIFO plus wr_stb in the same cycle as the IDLE pop -> push accepted, overflow stays 0, level stays 16.
- ovf_clr and a dropped push in the same cycle -> overflow remains 1; ovf_clr alone on the next cycle -> overflow 0.
- rst asserted during STROBE with 5 entries queued -> next cycle: ym_wr_n=1, ym_cs_n=1, level=0, fifo_empty=1, busy=0; no further strobes.
